// File: rtl/cmd_controller.sv
// cmd_controller: sequences one SD command through the CMD physical layer and collects its response.
module cmd_controller #(
  parameter int WATCHDOG_CYCLES = 256,
  parameter int WD_WIDTH = 9
) (
  input  logic        CLK_SD_card,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_argument,
  input  logic [1:0]  resp_type,
  input  logic        physical_inactive,
  output logic        new_cmd,
  output logic [37:0] cmd_index_arg,
  output logic        REQ_out,
  input  logic        ACK_in,
  input  logic        REQ_in,
  output logic        ACK_out,
  input  logic [37:0] cmd_response_in,
  output logic        busy,
  output logic        cmd_complete,
  output logic [31:0] response,
  output logic [5:0]  response_index,
  output logic        timeout_error,
  output logic        index_error
);
  typedef enum logic [2:0] {IDLE, LAUNCH, HANDSHAKE, WAIT_RESP, CAPTURE, DONE} state_t;
  localparam logic [WD_WIDTH-1:0] wd_last = WD_WIDTH'(WATCHDOG_CYCLES - 1);
  state_t state;
  logic [WD_WIDTH-1:0] wd;
  logic [5:0] idx;
  logic [1:0] rtype;
  always_ff @(posedge CLK_SD_card) begin
    if (reset) begin
      state <= IDLE;
      wd <= '0;
      idx <= '0;
      rtype <= '0;
      new_cmd <= 1'b0;
      cmd_index_arg <= '0;
      REQ_out <= 1'b0;
      ACK_out <= 1'b0;
      busy <= 1'b0;
      cmd_complete <= 1'b0;
      response <= '0;
      response_index <= '0;
      timeout_error <= 1'b0;
      index_error <= 1'b0;
    end else begin
      wd <= (state == IDLE) ? '0 : wd + 1'b1;
      new_cmd <= 1'b0;
      REQ_out <= 1'b0;
      ACK_out <= 1'b0;
      cmd_complete <= 1'b0;
      // DONE is excluded so a normal finish landing on the limit does not stretch the pulse
      if (state != IDLE && state != DONE && wd == wd_last) begin
        state <= DONE;
        cmd_complete <= 1'b1;
        timeout_error <= 1'b1;
      end else begin
        case (state)
          IDLE: if (cmd_start && physical_inactive) begin
            state <= LAUNCH;
            idx <= cmd_index;
            rtype <= resp_type;
            cmd_index_arg <= {cmd_index, cmd_argument};
            timeout_error <= 1'b0;
            index_error <= 1'b0;
            new_cmd <= 1'b1;
            busy <= 1'b1;
          end
          LAUNCH: begin
            state <= physical_inactive ? LAUNCH : HANDSHAKE;
            new_cmd <= physical_inactive;
            REQ_out <= !physical_inactive;
          end
          HANDSHAKE: begin
            state <= ACK_in ? WAIT_RESP : HANDSHAKE;
            REQ_out <= !ACK_in;
          end
          WAIT_RESP: if (REQ_in) begin
            state <= CAPTURE;
            ACK_out <= 1'b1;
            response <= cmd_response_in[31:0];
            response_index <= cmd_response_in[37:32];
            index_error <= index_error | (rtype != 2'b10 && cmd_response_in[37:32] != idx);
          end else if (physical_inactive) begin
            state <= DONE;
            cmd_complete <= 1'b1;
            timeout_error <= timeout_error | (rtype != 2'b00);
          end
          CAPTURE: begin
            state <= REQ_in ? CAPTURE : DONE;
            ACK_out <= REQ_in;
            cmd_complete <= !REQ_in;
          end
          DONE: begin
            state <= IDLE;
            busy <= 1'b0;
            cmd_index_arg <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cmd_controller.sv
// tb_cmd_controller: directed bench with a behavioural CMD physical layer and a result scoreboard.
module tb_cmd_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, cmd_start = 1'b0;
  logic [5:0] cmd_index = '0;
  logic [31:0] cmd_argument = '0;
  logic [1:0] resp_type = '0;
  logic physical_inactive, new_cmd, REQ_out, ACK_in, REQ_in, ACK_out, busy, cmd_complete;
  logic timeout_error, index_error;
  logic [37:0] cmd_index_arg, cmd_response_in;
  logic [31:0] response;
  logic [5:0] response_index;
  int n_cmp = 0, n_err = 0, cyc = 0, launches = 0, cnt = 0, silence = 5;
  logic phy_busy, hs, prev_new = 1'b0, ack_en = 1'b1, resp_en = 1'b1;
  logic [37:0] resp_val = '0;
  logic [31:0] last_resp = '0;
  logic [5:0] last_ridx = '0;
  typedef struct packed {logic [31:0] resp; logic [5:0] ridx; logic te; logic ie;} exp_t;
  exp_t sb[$];

  cmd_controller #(.WATCHDOG_CYCLES(256), .WD_WIDTH(9)) dut (
    .CLK_SD_card(clk), .reset(reset), .cmd_start(cmd_start), .cmd_index(cmd_index),
    .cmd_argument(cmd_argument), .resp_type(resp_type), .physical_inactive(physical_inactive),
    .new_cmd(new_cmd), .cmd_index_arg(cmd_index_arg), .REQ_out(REQ_out), .ACK_in(ACK_in),
    .REQ_in(REQ_in), .ACK_out(ACK_out), .cmd_response_in(cmd_response_in), .busy(busy),
    .cmd_complete(cmd_complete), .response(response), .response_index(response_index),
    .timeout_error(timeout_error), .index_error(index_error)
  );

  assign physical_inactive = !phy_busy;
  assign ACK_in = REQ_out & ack_en;
  assign cmd_response_in = resp_val;

  // physical layer: SETUP on new_cmd, launch handshake, then either a response or silence
  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_new <= new_cmd;
    if (new_cmd && !prev_new) launches <= launches + 1;
    if (reset || cmd_complete) begin
      phy_busy <= 1'b0; hs <= 1'b0; cnt <= 0; REQ_in <= 1'b0;
    end else if (!phy_busy) begin
      if (new_cmd) begin phy_busy <= 1'b1; hs <= 1'b0; cnt <= 0; end
    end else if (!hs) begin
      if (REQ_out && ACK_in) hs <= 1'b1;
    end else begin
      cnt <= cnt + 1;
      if (REQ_in && ACK_out) begin REQ_in <= 1'b0; phy_busy <= 1'b0; end
      else if (resp_en && cnt == 3) REQ_in <= 1'b1;
      else if (!resp_en && cnt == silence) phy_busy <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (REQ_out) begin ok = 1; break; end
      step();
    end
  endtask

  // mode 0: response returned, 1: silent return to inactive, 2: launch never acknowledged
  task automatic run(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                     input int mode, input logic [37:0] rv, input bit dup);
    exp_t e, g;
    int t0, l0;
    bit ok;
    ack_en = (mode != 2);
    resp_en = (mode == 0);
    resp_val = rv;
    e.resp = (mode == 0) ? rv[31:0] : last_resp;
    e.ridx = (mode == 0) ? rv[37:32] : last_ridx;
    e.te = (mode == 2) || (mode == 1 && rt != 2'b00);
    e.ie = (mode == 0) && rt != 2'b10 && rv[37:32] != idx;
    sb.push_back(e);
    last_resp = e.resp;
    last_ridx = e.ridx;
    l0 = launches;
    cmd_index = idx; cmd_argument = arg; resp_type = rt; cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    chk("launch_new_cmd", new_cmd, 1);
    chk("launch_busy", busy, 1);
    t0 = cyc;
    wait_req(ok);
    chk("req_seen", ok, 1);
    chk("index_arg", cmd_index_arg, {idx, arg});
    if (dup) begin
      cmd_index = 6'd63; cmd_start = 1'b1;
      step();
      cmd_start = 1'b0;
    end
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (cmd_complete) begin ok = 1; break; end
      step();
    end
    chk("complete_seen", ok, 1);
    g = sb.pop_front();
    chk("response", response, g.resp);
    chk("response_index", response_index, g.ridx);
    chk("timeout_error", timeout_error, g.te);
    chk("index_error", index_error, g.ie);
    if (mode == 2) begin
      chk("wd_latency", cyc - t0, 256);
      chk("wd_req_low", REQ_out, 0);
    end
    step();
    chk("complete_pulse", cmd_complete, 0);
    chk("idle_busy", busy, 0);
    chk("idle_index_arg", cmd_index_arg, 0);
    chk("launch_count", launches - l0, 1);
  endtask

  initial begin
    bit ok;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_new_cmd", new_cmd, 0);
    chk("rst_req", REQ_out, 0);
    chk("rst_ack", ACK_out, 0);
    chk("rst_complete", cmd_complete, 0);
    chk("rst_response", response, 0);
    chk("rst_errors", {timeout_error, index_error}, 0);
    reset = 1'b0;
    step();
    run(6'd17, 32'h0000_01AA, 2'b01, 0, {6'd17, 32'h0000_0120}, 0);
    silence = 5;
    run(6'd0, 32'h0, 2'b00, 1, 38'h0, 0);
    silence = 64;
    run(6'd2, 32'h12, 2'b01, 1, 38'h0, 0);
    run(6'd8, 32'h8, 2'b01, 0, {6'd9, 32'hDEAD_BEEF}, 0);
    run(6'd8, 32'h8, 2'b10, 0, {6'd9, 32'h0000_1234}, 0);
    run(6'd1, 32'h77, 2'b01, 2, 38'h0, 0);
    ack_en = 1'b0;
    cmd_index = 6'd3; cmd_argument = 32'h55; resp_type = 2'b01; cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    wait_req(ok);
    chk("hs_req_seen", ok, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_req", REQ_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_new_cmd", new_cmd, 0);
    chk("midrst_response", response, 0);
    chk("midrst_te", timeout_error, 0);
    last_resp = '0;
    last_ridx = '0;
    step();
    run(6'd5, 32'h0000_ABCD, 2'b10, 0, {6'd5, 32'h0000_CAFE}, 1);
    chk("sb_empty", sb.size(), 0);
    chk("total_launches", launches, 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed cycle %0d required completion", cyc);
    $fatal(1, "bench did not finish");
  end
endmodule
